ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Sits directly downstream of the team's simple dual-port block RAM and drives its read port: rden, rdaddr in; registered read data back.
- On a start command it reads `len` consecutive words from `base_addr` and presents them in order on a valid/ready stream.
- Absorbs the RAM's 1-cycle read latency with a 2-entry output buffer, so downstream backpressure never drops or duplicates a word.
- Single clock domain; the RAM's wrclk and rdclk are tied to the same `clk` at integration.

Parameters:
- DWIDTH, 16, data word width (matches RAM).
- AWIDTH, 7, RAM address width; depth = 2^AWIDTH.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  AWIDTH  first read address; captured with start.
- len  input  AWIDTH+1  word count, 0..2^AWIDTH; captured with start.
- busy  output  1  high while a command is in progress.
- done  output  1  single-cycle completion pulse.
- rden  output  1  RAM read enable.
- rdaddr  output  AWIDTH  RAM read address.
- rd_do  input  DWIDTH  RAM registered read data; valid the cycle after rden.
- dout  output  DWIDTH  stream data.
- dout_valid  output  1  stream valid.
- dout_ready  input  1  stream ready from the consumer.

Behaviour:
- Reset, synchronous and active-high: state=IDLE; busy=0, done=0, rden=0, rdaddr=0, dout_valid=0, dout=0.
  - Reset also clears the buffer, the in-flight flag, and the address and remaining counters.
  - Reset mid-operation abandons the command. Any word in flight from the RAM is discarded and done is not pulsed.
- States:
  - IDLE: busy=0. If start=1 and len!=0 → READ, capturing addr=base_addr and rem=len. If start=1 and len==0 → DONE. A start seen outside IDLE is ignored.
  - READ: busy=1. Issues reads per the credit rule. When the last read issues (rem 1→0) → DRAIN.
  - DRAIN: busy=1, rden=0. When the final word is accepted (dout_valid & dout_ready, buffer then empty, nothing in flight) → DONE.
  - DONE: done=1 and busy=0 for exactly one cycle → IDLE. A start may be sampled in the cycle after done.
- Credit rule: rden=1 in READ when rem!=0 and (occ + inflight − pop) < 2.
  - occ = buffer occupancy (0..2).
  - inflight = rden registered, i.e. a read was issued last cycle.
  - pop = dout_valid & dout_ready.
- rden and rdaddr are combinational from state and counters. rdaddr=addr.
- On each issue: addr ← addr+1, wrapping modulo 2^AWIDTH (for example 127 → 0), and rem ← rem−1.
- When inflight=1, rd_do is pushed into the buffer that cycle. Push and pop in the same cycle are legal.
- dout and dout_valid come from the buffer head and are registered.
  - The first word appears 3 cycles after the start-sampled cycle: cycle 1 rden, cycle 2 rd_do, cycle 3 dout_valid.
  - While dout_valid=1 and dout_ready=0, dout is held stable.
- Throughput: one word per cycle sustained with dout_ready held high.
- The buffer never overflows, by construction of the credit rule. Overflow is an assertion failure in simulation.

Test Plan:
- Bench RAM is preloaded with addr0..9 = 0001, AAAA, 5555, FFFF, F0F0, 0F0F, CCCC, 3333, 0002, 0004.
- Sanity read: start with base=0, len=4, ready=1 → dout 0001, AAAA, 5555, FFFF on 4 consecutive cycles starting 3 cycles after start; done pulses once, the cycle after the last accept; busy then 0.
- Backpressure: base=2, len=6, ready toggling 1,0,0,1,… → sequence 5555, FFFF, F0F0, 0F0F, CCCC, 3333 exactly once each, in order, with dout stable while stalled; rden never issues when occ+inflight would exceed 2.
- Wrap and full length: base=126, len=4 → rdaddr 126, 127, 0, 1 and data ram[126], ram[127], 0001, AAAA. Separately, len=128 from base=0 → 128 words, then a single done pulse.
- Zero length: start with len=0 → no rden, done pulses 1 cycle after start, busy stays 0.
- Start while busy: a second start mid-command with different base/len is ignored; output matches the first command only.
- Reset mid-transfer: assert reset during DRAIN with ready=0 → the next cycle shows all outputs 0 and no done. A new command (base=8, len=2) then yields 0002, 0004 only.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of ram_stream_reader.
// master is the reader itself; slave is the environment driving it.
interface ram_stream_reader_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
);
  logic              start;
  logic [AWIDTH-1:0] base_addr;
  logic [AWIDTH:0]   len;
  logic              busy;
  logic              done;
  logic              rden;
  logic [AWIDTH-1:0] rdaddr;
  logic [DWIDTH-1:0] rd_do;
  logic [DWIDTH-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    input  start, base_addr, len, rd_do, dout_ready,
    output busy, done, rden, rdaddr, dout, dout_valid
  );

  modport slave (
    output start, base_addr, len, rd_do, dout_ready,
    input  busy, done, rden, rdaddr, dout, dout_valid
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads len consecutive words from a 1-cycle-latency block RAM and streams them
// out on valid/ready, using a 2-entry buffer and a credit check on each read.
module ram_stream_reader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
) (
  input  logic                clk,
  input  logic                reset,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH:0]   rem;
  logic              vld_p1;
  logic [DWIDTH-1:0] ent_p2 [2];
  logic [1:0]        occ_p2;
  logic              issue;
  logic              pop;
  logic [2:0]        committed;

  // Words already owed to the buffer after this cycle's pop; a new read needs room.
  assign pop       = (occ_p2 != 2'd0) && bus.dout_ready;
  assign committed = {1'b0, occ_p2} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue     = (state == READ) && (rem != '0) && (committed < 3'd2);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len != '0) ? READ : DONE;
      READ:  if (issue && (rem == (AWIDTH+1)'(1))) state_nxt = DRAIN;
      DRAIN: if (pop && (occ_p2 == 2'd1) && !vld_p1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy       = (state == READ) || (state == DRAIN);
  assign bus.done       = (state == DONE);
  assign bus.rden       = issue;
  assign bus.rdaddr     = addr;
  assign bus.dout       = ent_p2[0];
  assign bus.dout_valid = (occ_p2 != 2'd0);

  // Stage p0 -> p1: issue read, advance address and remaining count
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= '0;
      rem    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= issue;
      if ((state == IDLE) && bus.start) begin
        addr <= bus.base_addr;
        rem  <= bus.len;
      end else if (issue) begin
        addr <= addr + 1'b1;
        rem  <= rem - 1'b1;
      end
    end
  end

  // Stage p1 -> p2: capture RAM data into the buffer; entry 0 is the stream head
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_p2    <= '0;
      ent_p2[0] <= '0;
      ent_p2[1] <= '0;
    end else begin
      unique case ({vld_p1, pop})
        2'b10: begin
          if (occ_p2 == 2'd0) ent_p2[0] <= bus.rd_do;
          else                ent_p2[1] <= bus.rd_do;
          occ_p2 <= occ_p2 + 2'd1;
        end
        2'b01: begin
          ent_p2[0] <= ent_p2[1];
          occ_p2    <= occ_p2 - 2'd1;
        end
        2'b11: begin
          if (occ_p2 == 2'd1) begin
            ent_p2[0] <= bus.rd_do;
          end else begin
            ent_p2[0] <= ent_p2[1];
            ent_p2[1] <= bus.rd_do;
          end
        end
        default: ;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(vld_p1 && !pop && (occ_p2 == 2'd2)));
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: bench-side RAM, command table, hand sequences
// and randomized commands checked against an address/queue reference model.
module tb_ram_stream_reader;
  localparam int DW    = 16;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  ram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.rden) bus.rd_do <= ram[bus.rdaddr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            base;
    int            len;
    int            rmode;
    int            restart_at;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  // Runs one command; the expected stream is simply ram[base+i mod DEPTH], i < len.
  task automatic run_cmd(input int base, input int len, input int rmode, input int restart_at,
                         output logic [DW-1:0] first_w, output logic [DW-1:0] last_w,
                         output int n_acc);
    logic [DW-1:0] expq[$];
    int issued, accepted, done_cnt, last_acc_c, first_vld_c, c, budget;
    bit prev_stall, r, fin, exp_busy;
    logic [DW-1:0] prev_dout;
    expq = {};
    for (int i = 0; i < len; i++) expq.push_back(ram[(base + i) % DEPTH]);
    issued = 0; accepted = 0; done_cnt = 0; last_acc_c = 0; first_vld_c = -1;
    prev_stall = 1'b0; prev_dout = '0; first_w = '0; last_w = '0;
    budget = 8 * len + 30;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = AW'(base);
    bus.len        = (AW+1)'(len);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    fin = 1'b0;
    c = 0;
    while (!fin && c < budget) begin
      c++;
      @(posedge clk); #1;
      bus.start = (c == restart_at);
      if (c == restart_at) begin
        bus.base_addr = AW'(base + 5);
        bus.len       = (AW+1)'(len + 3);
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = ((c % 3) == 0);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      bus.dout_ready = r;
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, bus.dout_valid}, 32'd1);
        chk("stall_dout", {16'd0, bus.dout}, {16'd0, prev_dout});
      end
      if (bus.rden) begin
        chk("rdaddr", {25'd0, bus.rdaddr}, (base + issued) % DEPTH);
        issued++;
      end
      if (bus.dout_valid && first_vld_c < 0) first_vld_c = c;
      if (bus.dout_valid && r) begin
        if (accepted < len) begin
          chk("data", {16'd0, bus.dout}, {16'd0, expq[accepted]});
          if (accepted == 0) first_w = bus.dout;
          last_w = bus.dout;
        end else begin
          chk("extra_word", accepted + 1, len);
        end
        accepted++;
        last_acc_c = c;
      end
      chk("outstanding", {31'd0, (issued - accepted) <= 2}, 32'd1);
      exp_busy = (len != 0) && (done_cnt == 0) && !bus.done;
      chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      if (bus.done) begin
        done_cnt++;
        chk("done_timing", c, last_acc_c + 1);
        fin = 1'b1;
      end
      prev_stall = bus.dout_valid && !r;
      prev_dout  = bus.dout;
    end
    chk("done_seen", done_cnt, 1);
    chk("issued", issued, len);
    chk("accepted", accepted, len);
    if (len != 0) chk("first_valid_cycle", first_vld_c, 3);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_quiet", {28'd0, bus.busy, bus.done, bus.rden, bus.dout_valid}, 32'd0);
    end
    if (!fin) begin
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
    end
    n_acc = accepted;
  endtask

  vec_t tbl[8];

  initial begin
    logic [DW-1:0] fw, lw;
    int n;
    for (int a = 0; a < DEPTH; a++) ram[a] = 16'($urandom);
    ram[0] = 16'h0001; ram[1] = 16'hAAAA; ram[2] = 16'h5555; ram[3] = 16'hFFFF;
    ram[4] = 16'hF0F0; ram[5] = 16'h0F0F; ram[6] = 16'hCCCC; ram[7] = 16'h3333;
    ram[8] = 16'h0002; ram[9] = 16'h0004;
    ram[126] = 16'h7E7E; ram[127] = 16'h7F7F;

    tbl[0] = '{0,   4,   0, -1, 16'h0001, 16'hFFFF};
    tbl[1] = '{2,   6,   1, -1, 16'h5555, 16'h3333};
    tbl[2] = '{126, 4,   0, -1, 16'h7E7E, 16'hAAAA};
    tbl[3] = '{126, 4,   1, -1, 16'h7E7E, 16'hAAAA};
    tbl[4] = '{0,   128, 0, -1, 16'h0001, 16'h7F7F};
    tbl[5] = '{0,   0,   0, -1, 16'h0000, 16'h0000};
    tbl[6] = '{0,   4,   0,  2, 16'h0001, 16'hFFFF};
    tbl[7] = '{2,   6,   2, -1, 16'h5555, 16'h3333};

    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy},       32'd0);
    chk("rst_done",   {31'd0, bus.done},       32'd0);
    chk("rst_rden",   {31'd0, bus.rden},       32'd0);
    chk("rst_rdaddr", {25'd0, bus.rdaddr},     32'd0);
    chk("rst_valid",  {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_dout",   {16'd0, bus.dout},       32'd0);
    @(posedge clk); #1; reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_cmd(tbl[v].base, tbl[v].len, tbl[v].rmode, tbl[v].restart_at, fw, lw, n);
      chk("tbl_first", {16'd0, fw}, {16'd0, tbl[v].exp_first});
      chk("tbl_last",  {16'd0, lw}, {16'd0, tbl[v].exp_last});
      chk("tbl_count", n, tbl[v].len);
    end

    // Reset while draining with the consumer stalled; the in-flight word must vanish.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = '0; bus.len = 8'd2; bus.dout_ready = 1'b0;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_busy",  {31'd0, bus.busy},       32'd1);
    chk("drain_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("drain_rden",  {31'd0, bus.rden},       32'd0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs",
        {bus.busy, bus.done, bus.rden, bus.dout_valid, 28'd0}, 32'd0);
    chk("mid_rst_rdaddr", {25'd0, bus.rdaddr}, 32'd0);
    chk("mid_rst_dout",   {16'd0, bus.dout},   32'd0);
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_rst_quiet", {30'd0, bus.done, bus.dout_valid}, 32'd0);
    end
    run_cmd(8, 2, 0, -1, fw, lw, n);
    chk("post_rst_first", {16'd0, fw}, 32'h0002);
    chk("post_rst_last",  {16'd0, lw}, 32'h0004);
    chk("post_rst_count", n, 2);

    for (int t = 0; t < 25; t++) begin
      int b, l, m, rs;
      b  = $urandom_range(0, DEPTH - 1);
      l  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH) : $urandom_range(0, 12);
      m  = $urandom_range(0, 2);
      rs = (l > 0 && $urandom_range(0, 1) == 1) ? 2 : -1;
      run_cmd(b, l, m, rs, fw, lw, n);
      chk("rand_count", n, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
